// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - direct-mapped BHT with tagged target buffer and optional gshare indexing
//
// Purpose:
//   Predicts branch direction and target at IF from the fetch PC, and trains
//   the table when the branch resolves in ID. Each entry holds a valid bit,
//   a tag, a word-aligned target and a saturating counter. With MODE=1 the
//   index is hashed with a global history register (gshare).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pc_i                fetch PC
//   pred_taken_o        predicted taken
//   pred_target_o       predicted target, 0 when not predicted taken
//   pred_idx_o          table index used for this lookup
//   upd_valid_i         a resolved branch/jump is presented this cycle
//   upd_idx_i           index carried from the prediction
//   upd_pc_i            PC of the resolved instruction
//   upd_taken_i         actual direction
//   upd_target_i        actual target
//   upd_pred_taken_i    direction that was predicted
//   upd_pred_target_i   target that was predicted
//   mispredict_o        combinational mispredict flag for the current update
//   flush_i             invalidate all entries and clear history
//   stat_pred_o         saturating count of accepted updates
//   stat_miss_o         saturating count of accepted mispredicted updates

module branch_predictor_bht #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 64,
  parameter int CTR_BITS  = 2,
  parameter int HIST_BITS = 6,
  parameter int MODE      = 0,
  parameter int STAT_BITS = 16,
  localparam int IDX      = $clog2(ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      pc_i,
  output logic                 pred_taken_o,
  output logic [XLEN-1:0]      pred_target_o,
  output logic [IDX-1:0]       pred_idx_o,
  input  logic                 upd_valid_i,
  input  logic [IDX-1:0]       upd_idx_i,
  input  logic [XLEN-1:0]      upd_pc_i,
  input  logic                 upd_taken_i,
  input  logic [XLEN-1:0]      upd_target_i,
  input  logic                 upd_pred_taken_i,
  input  logic [XLEN-1:0]      upd_pred_target_i,
  output logic                 mispredict_o,
  input  logic                 flush_i,
  output logic [STAT_BITS-1:0] stat_pred_o,
  output logic [STAT_BITS-1:0] stat_miss_o
);

  localparam int TAG_W = XLEN - IDX - 2;
  localparam int TGT_W = XLEN - 2;

  // Freshly allocated entries start weakly taken: MSB set, rest clear.
  localparam logic [CTR_BITS-1:0] CTR_WEAK = {1'b1, {(CTR_BITS-1){1'b0}}};

  // Table storage (flip-flops, read asynchronously)
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q [ENTRIES];
  logic [TGT_W-1:0]    tgt_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];

  logic [HIST_BITS-1:0] ghr_q;
  logic [IDX-1:0]       ghr_ext;

  logic [STAT_BITS-1:0] stat_pred_q;
  logic [STAT_BITS-1:0] stat_miss_q;

  // Lookup
  logic [IDX-1:0]   pc_idx;
  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  // Update
  logic             upd_en;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_inc;
  logic [CTR_BITS-1:0] ctr_dec;

  // Low PC/target bits are implied zero by word alignment.
  logic unused_bits;
  assign unused_bits = ^{pc_i[1:0], upd_pc_i[IDX+1:0], upd_target_i[1:0]};

  // History is zero-extended to the index width before hashing.
  always_comb begin
    ghr_ext = '0;
    ghr_ext[HIST_BITS-1:0] = ghr_q;
  end

  assign pc_idx = pc_i[IDX+1:2];
  assign lk_idx = (MODE == 1) ? (pc_idx ^ ghr_ext) : pc_idx;
  assign lk_tag = pc_i[XLEN-1:IDX+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign pred_idx_o    = lk_idx;
  assign pred_taken_o  = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
  assign pred_target_o = pred_taken_o ? {tgt_q[lk_idx], 2'b00} : '0;

  assign mispredict_o = upd_valid_i &&
                        ((upd_taken_i != upd_pred_taken_i) ||
                         (upd_taken_i && (upd_target_i != upd_pred_target_i)));

  // Flush wins over a coincident update; the update is dropped entirely,
  // including its contribution to history and statistics.
  assign upd_en  = upd_valid_i && !flush_i;
  assign upd_tag = upd_pc_i[XLEN-1:IDX+2];
  assign upd_hit = valid_q[upd_idx_i] && (tag_q[upd_idx_i] == upd_tag);

  assign ctr_cur = ctr_q[upd_idx_i];
  assign ctr_inc = (ctr_cur == '1) ? ctr_cur : ctr_cur + 1'b1;
  assign ctr_dec = (ctr_cur == '0) ? ctr_cur : ctr_cur - 1'b1;

  // Valid bits and counters carry reset; flush only clears valid, leaving
  // counters stale behind an invalid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= '0;
      end
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (upd_en) begin
      if (upd_hit) begin
        ctr_q[upd_idx_i] <= upd_taken_i ? ctr_inc : ctr_dec;
      end else if (upd_taken_i) begin
        valid_q[upd_idx_i] <= 1'b1;
        ctr_q[upd_idx_i]   <= CTR_WEAK;
      end
    end
  end

  // Tag and target need no reset: they are only observed behind valid.
  // On a hit the tag rewrite is a no-op, so both cases share one write.
  always_ff @(posedge clk) begin
    if (upd_en && upd_taken_i) begin
      tag_q[upd_idx_i] <= upd_tag;
      tgt_q[upd_idx_i] <= upd_target_i[XLEN-1:2];
    end
  end

  generate
    if (MODE == 1) begin : g_ghr
      // Newest outcome enters at bit 0.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ghr_q <= '0;
        end else if (flush_i) begin
          ghr_q <= '0;
        end else if (upd_en) begin
          ghr_q <= (ghr_q << 1) | HIST_BITS'(upd_taken_i);
        end
      end
    end else begin : g_no_ghr
      assign ghr_q = '0;
    end
  endgenerate

  // Statistics saturate rather than wrap and survive flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pred_q <= '0;
      stat_miss_q <= '0;
    end else if (upd_en) begin
      if (stat_pred_q != '1) begin
        stat_pred_q <= stat_pred_q + 1'b1;
      end
      if (mispredict_o && (stat_miss_q != '1)) begin
        stat_miss_q <= stat_miss_q + 1'b1;
      end
    end
  end

  assign stat_pred_o = stat_pred_q;
  assign stat_miss_o = stat_miss_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - self-checking bench for branch_predictor_bht (bimodal and gshare)

module tb_branch_predictor_bht;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Bimodal instance (a_*)
  logic [31:0] a_pc = '0;
  logic        a_pred_taken;
  logic [31:0] a_pred_target;
  logic [5:0]  a_pred_idx;
  logic        a_upd_valid = 1'b0;
  logic [5:0]  a_upd_idx = '0;
  logic [31:0] a_upd_pc = '0;
  logic        a_upd_taken = 1'b0;
  logic [31:0] a_upd_target = '0;
  logic        a_upd_pred_taken = 1'b0;
  logic [31:0] a_upd_pred_target = '0;
  logic        a_mispredict;
  logic        a_flush = 1'b0;
  logic [15:0] a_stat_pred;
  logic [15:0] a_stat_miss;

  // Gshare instance (g_*), narrow stats to exercise saturation
  logic [31:0] g_pc = '0;
  logic        g_pred_taken;
  logic [31:0] g_pred_target;
  logic [5:0]  g_pred_idx;
  logic        g_upd_valid = 1'b0;
  logic [5:0]  g_upd_idx = '0;
  logic [31:0] g_upd_pc = '0;
  logic        g_upd_taken = 1'b0;
  logic [31:0] g_upd_target = '0;
  logic        g_upd_pred_taken = 1'b0;
  logic [31:0] g_upd_pred_target = '0;
  logic        g_mispredict;
  logic        g_flush = 1'b0;
  logic [3:0]  g_stat_pred;
  logic [3:0]  g_stat_miss;

  branch_predictor_bht #(.XLEN(32), .ENTRIES(64), .CTR_BITS(2), .HIST_BITS(6),
                         .MODE(0), .STAT_BITS(16)) u_bim (
    .clk(clk), .rst(rst), .pc_i(a_pc),
    .pred_taken_o(a_pred_taken), .pred_target_o(a_pred_target), .pred_idx_o(a_pred_idx),
    .upd_valid_i(a_upd_valid), .upd_idx_i(a_upd_idx), .upd_pc_i(a_upd_pc),
    .upd_taken_i(a_upd_taken), .upd_target_i(a_upd_target),
    .upd_pred_taken_i(a_upd_pred_taken), .upd_pred_target_i(a_upd_pred_target),
    .mispredict_o(a_mispredict), .flush_i(a_flush),
    .stat_pred_o(a_stat_pred), .stat_miss_o(a_stat_miss)
  );

  branch_predictor_bht #(.XLEN(32), .ENTRIES(64), .CTR_BITS(2), .HIST_BITS(2),
                         .MODE(1), .STAT_BITS(4)) u_gsh (
    .clk(clk), .rst(rst), .pc_i(g_pc),
    .pred_taken_o(g_pred_taken), .pred_target_o(g_pred_target), .pred_idx_o(g_pred_idx),
    .upd_valid_i(g_upd_valid), .upd_idx_i(g_upd_idx), .upd_pc_i(g_upd_pc),
    .upd_taken_i(g_upd_taken), .upd_target_i(g_upd_target),
    .upd_pred_taken_i(g_upd_pred_taken), .upd_pred_target_i(g_upd_pred_target),
    .mispredict_o(g_mispredict), .flush_i(g_flush),
    .stat_pred_o(g_stat_pred), .stat_miss_o(g_stat_miss)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  // Lookup at the negedge, compare prediction before the next posedge.
  task automatic a_lookup(input string tag, input logic [31:0] pc,
                          input logic exp_taken, input logic [31:0] exp_tgt);
    @(negedge clk);
    a_pc = pc;
    sb_push({tag, "_taken"}, 32'(exp_taken));
    sb_push({tag, "_target"}, exp_tgt);
    #1;
    sb_check(32'(a_pred_taken));
    sb_check(a_pred_target);
  endtask

  // Predict then resolve in the same cycle, feeding back the live prediction.
  task automatic a_update(input string tag, input logic [31:0] pc, input logic taken,
                          input logic [31:0] tgt, input logic exp_mis);
    @(negedge clk);
    a_pc = pc;
    #1;
    a_upd_idx         = a_pred_idx;
    a_upd_pc          = pc;
    a_upd_taken       = taken;
    a_upd_target      = tgt;
    a_upd_pred_taken  = a_pred_taken;
    a_upd_pred_target = a_pred_target;
    a_upd_valid       = 1'b1;
    sb_push({tag, "_mis"}, 32'(exp_mis));
    #1;
    sb_check(32'(a_mispredict));
    @(posedge clk);
    #1;
    a_upd_valid = 1'b0;
  endtask

  // Combinational mispredict probe; update is withdrawn before the edge.
  task automatic a_mis_probe(input string tag, input logic valid, input logic taken,
                             input logic [31:0] tgt, input logic ptaken,
                             input logic [31:0] ptgt, input logic exp_mis);
    @(negedge clk);
    a_upd_valid       = valid;
    a_upd_taken       = taken;
    a_upd_target      = tgt;
    a_upd_pred_taken  = ptaken;
    a_upd_pred_target = ptgt;
    a_upd_pc          = 32'h0000_0300;
    a_upd_idx         = 6'd0;
    sb_push(tag, 32'(exp_mis));
    #1;
    sb_check(32'(a_mispredict));
    #1;
    a_upd_valid = 1'b0;
  endtask

  task automatic a_stats(input string tag, input int exp_pred, input int exp_miss);
    sb_push({tag, "_stat_pred"}, 32'(exp_pred));
    sb_push({tag, "_stat_miss"}, 32'(exp_miss));
    sb_check(32'(a_stat_pred));
    sb_check(32'(a_stat_miss));
  endtask

  task automatic g_update(input string tag, input logic taken, input logic exp_mis);
    @(negedge clk);
    g_pc = 32'h0000_0100;
    #1;
    g_upd_idx         = g_pred_idx;
    g_upd_pc          = 32'h0000_0100;
    g_upd_taken       = taken;
    g_upd_target      = 32'h0000_0080;
    g_upd_pred_taken  = g_pred_taken;
    g_upd_pred_target = g_pred_target;
    g_upd_valid       = 1'b1;
    sb_push(tag, 32'(exp_mis));
    #1;
    sb_check(32'(g_mispredict));
    @(posedge clk);
    #1;
    g_upd_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    a_pc = 32'h0000_0100;
    g_pc = 32'h0000_0100;
    #2;
    sb_push("rst_taken", 32'd0);   sb_check(32'(a_pred_taken));
    sb_push("rst_target", 32'd0);  sb_check(a_pred_target);
    sb_push("rst_mis", 32'd0);     sb_check(32'(a_mispredict));
    a_stats("rst", 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // First allocation
    a_update("alloc", 32'h0000_0100, 1'b1, 32'h0000_0080, 1'b1);
    a_lookup("alloc_lk", 32'h0000_0100, 1'b1, 32'h0000_0080);
    a_stats("alloc", 1, 1);

    // Counter saturation in both directions (10 -> 11 -> 11 -> 11)
    for (int i = 0; i < 3; i++) a_update("t3", 32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0);
    a_update("n1", 32'h0000_0100, 1'b0, 32'h0, 1'b1);
    a_lookup("n1_lk", 32'h0000_0100, 1'b1, 32'h0000_0080);
    a_update("n2", 32'h0000_0100, 1'b0, 32'h0, 1'b1);
    a_lookup("n2_lk", 32'h0000_0100, 1'b0, 32'h0);
    a_update("n3", 32'h0000_0100, 1'b0, 32'h0, 1'b0);
    a_update("n4", 32'h0000_0100, 1'b0, 32'h0, 1'b0);
    a_lookup("n4_lk", 32'h0000_0100, 1'b0, 32'h0);
    a_update("t_lo1", 32'h0000_0100, 1'b1, 32'h0000_0080, 1'b1);
    a_lookup("t_lo1_lk", 32'h0000_0100, 1'b0, 32'h0);
    a_update("t_lo2", 32'h0000_0100, 1'b1, 32'h0000_0080, 1'b1);
    a_lookup("t_lo2_lk", 32'h0000_0100, 1'b1, 32'h0000_0080);
    a_stats("train", 10, 5);

    // Aliasing replacement and target overwrite on hit
    a_update("alias", 32'h0000_0200, 1'b1, 32'h0000_0040, 1'b1);
    a_lookup("alias_old", 32'h0000_0100, 1'b0, 32'h0);
    a_lookup("alias_new", 32'h0000_0200, 1'b1, 32'h0000_0040);
    a_update("retarget", 32'h0000_0200, 1'b1, 32'h0000_0060, 1'b1);
    a_lookup("retarget_lk", 32'h0000_0200, 1'b1, 32'h0000_0060);
    a_lookup("idx1", 32'h0000_0204, 1'b0, 32'h0);
    sb_push("idx1_idx", 32'd1);
    sb_check(32'(a_pred_idx));

    // Mispredict flag cases
    a_mis_probe("mis_tgt", 1'b1, 1'b1, 32'h80, 1'b1, 32'h84, 1'b1);
    a_mis_probe("mis_ok", 1'b1, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
    a_mis_probe("mis_nt_tgt", 1'b1, 1'b0, 32'h80, 1'b0, 32'h84, 1'b0);
    a_mis_probe("mis_idle", 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);

    // Flush with coincident update
    a_update("pre_flush", 32'h0000_0100, 1'b1, 32'h0000_0080, 1'b1);
    a_stats("pre_flush", 13, 8);
    @(negedge clk);
    a_pc = 32'h0000_0100;
    #1;
    a_upd_idx = a_pred_idx; a_upd_pc = 32'h0000_0100; a_upd_taken = 1'b1;
    a_upd_target = 32'h0000_00c0; a_upd_pred_taken = a_pred_taken;
    a_upd_pred_target = a_pred_target;
    a_upd_valid = 1'b1; a_flush = 1'b1;
    @(posedge clk);
    #1;
    a_upd_valid = 1'b0; a_flush = 1'b0;
    a_lookup("flush_100", 32'h0000_0100, 1'b0, 32'h0);
    a_lookup("flush_204", 32'h0000_0200, 1'b0, 32'h0);
    a_stats("flush", 13, 8);

    // Same-cycle lookup and update: old contents visible until the edge
    @(negedge clk);
    a_pc = 32'h0000_0100;
    a_upd_idx = 6'd0; a_upd_pc = 32'h0000_0100; a_upd_taken = 1'b1;
    a_upd_target = 32'h0000_0080; a_upd_pred_taken = 1'b0; a_upd_pred_target = 32'h0;
    a_upd_valid = 1'b1;
    sb_push("bypass_old", 32'd0);
    #1;
    sb_check(32'(a_pred_taken));
    @(posedge clk);
    #1;
    a_upd_valid = 1'b0;
    @(negedge clk);
    sb_push("bypass_new", 32'd1);
    sb_check(32'(a_pred_taken));
    a_stats("bypass", 14, 9);

    // Asynchronous reset mid-run
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb_push("arst_taken", 32'd0);   sb_check(32'(a_pred_taken));
    sb_push("arst_target", 32'd0);  sb_check(a_pred_target);
    a_stats("arst", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    a_update("post_rst", 32'h0000_0100, 1'b1, 32'h0000_0080, 1'b1);
    a_lookup("post_rst_lk", 32'h0000_0100, 1'b1, 32'h0000_0080);

    // Gshare: T,T,N repeated; only warm-up predictions miss
    for (int p = 0; p < 12; p++) begin
      g_update($sformatf("gs_p%0d_0", p), 1'b1, (p == 0) || (p == 1));
      g_update($sformatf("gs_p%0d_1", p), 1'b1, (p == 0));
      g_update($sformatf("gs_p%0d_2", p), 1'b0, 1'b0);
    end
    @(negedge clk);
    g_pc = 32'h0000_0100;
    sb_push("gs_idx_ghr", 32'd2);
    sb_push("gs_final_pred", 32'd1);
    sb_push("gs_stat_pred_sat", 32'd15);
    sb_push("gs_stat_miss", 32'd3);
    #1;
    sb_check(32'(g_pred_idx));
    sb_check(32'(g_pred_taken));
    sb_check(32'(g_stat_pred));
    sb_check(32'(g_stat_miss));

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got %0d checks expected completion", checks);
    $fatal(1);
  end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised successor to the single-entry branch predictor used by the 5-stage RISC-V pipeline.
- Direct-mapped branch history table with N-bit saturating counters and a tagged target buffer. Optional gshare indexing through a global history register.
- Prediction is combinational at IF from the fetch PC. Training happens at branch resolution in ID.
- Also exposes one-cycle table flush, a mispredict indication, and saturating prediction/mispredict statistics counters.

Parameters:
XLEN, 32, address/data width
ENTRIES, 64, table entries; power of 2, 4..1024; IDX = log2(ENTRIES)
CTR_BITS, 2, saturating counter width, 2..4
HIST_BITS, 6, global history length, 1..IDX
MODE, 0, 0 = bimodal (index = pc[IDX+1:2]); 1 = gshare (index = pc[IDX+1:2] XOR zero-extended GHR)
STAT_BITS, 16, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
pc_i  in  XLEN  fetch PC from IF
pred_taken_o  out  1  predicted taken
pred_target_o  out  XLEN  predicted target (0 when not taken)
pred_idx_o  out  IDX  table index used; carried down the pipe with the instruction
upd_valid_i  in  1  resolved branch/jump in ID this cycle; caller deasserts during stall
upd_idx_i  in  IDX  index carried from prediction
upd_pc_i  in  XLEN  PC of the resolved instruction
upd_taken_i  in  1  actual outcome
upd_target_i  in  XLEN  actual target
upd_pred_taken_i  in  1  prediction carried with the instruction
upd_pred_target_i  in  XLEN  predicted target carried with the instruction
mispredict_o  out  1  combinational mispredict flag for the current update
flush_i  in  1  invalidate all entries and clear GHR
stat_pred_o  out  STAT_BITS  resolved-branch count
stat_miss_o  out  STAT_BITS  mispredict count

Behaviour:
- Reset (async, rst=1): all valid bits=0, counters=0, GHR=0, stat counters=0.
  - Resulting outputs: pred_taken_o=0, pred_target_o=0, mispredict_o=0.
- Entry layout: valid, tag = pc[XLEN-1:IDX+2], target[XLEN-1:2], counter[CTR_BITS-1:0].
- Lookup (combinational):
  - idx = per MODE.
  - hit = valid[idx] and tag matches pc_i.
  - pred_taken_o = hit and counter MSB=1.
  - pred_target_o = {target,2'b00} when pred_taken_o, else 0.
  - pred_idx_o = idx, always driven.
- mispredict_o = upd_valid_i and (upd_taken_i != upd_pred_taken_i, or (upd_taken_i and upd_target_i != upd_pred_target_i)).
- Update (rising clk, upd_valid_i=1 and flush_i=0), entry at upd_idx_i:
  - Tag hit: counter +1 saturating at all-ones if taken, -1 saturating at 0 if not taken. Target overwritten with upd_target_i when taken.
  - Tag miss, taken: allocate/replace. valid=1, tag and target written, counter = weakly taken (MSB=1, remaining bits 0; e.g. 2'b10).
  - Tag miss, not taken: table unchanged.
  - MODE=1: GHR <= {GHR[HIST_BITS-2:0], upd_taken_i}. MODE=0: GHR unused, held at 0.
  - stat_pred_o +1; stat_miss_o +1 when mispredict_o. Both saturate at all-ones; no wrap.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update contents. No bypass. The new value is visible the following cycle.
- flush_i=1 at a clock edge:
  - Clears all valid bits and GHR in one cycle.
  - Counters and targets are left stale; they are harmless because valid=0.
  - A coincident update is discarded.
  - Stat counters are not cleared.
  - flush_i has priority over upd_valid_i.
- Reset asserted mid-operation: immediate return to the reset state, independent of clk. The table is usable on the first edge after rst deasserts.
- Single write port; at most one update per cycle.
- Storage is flip-flops, so reads are asynchronous.

Test Plan:
1. Reset, pc_i=0x100 -> pred_taken_o=0, pred_target_o=0, stat_pred_o=0. Assert rst mid-run after training -> same values immediately.
2. MODE=0. Update pc=0x100 (idx 0), taken, target=0x80, pred_taken=0 -> mispredict_o=1. Next cycle pc_i=0x100 -> taken, target 0x80, stat_miss_o=1.
3. Train 0x100: taken×3 then not-taken×2 -> after taken×3 counter=11; after not-taken×2 counter=01, prediction not taken. Two further not-taken -> counter stays 00.
4. Alias: train 0x100 taken, then update 0x200 (same idx when ENTRIES=64), taken, target 0x40 -> lookup 0x100 misses (pred 0); lookup 0x200 returns 0x40.
5. MODE=1, HIST_BITS=2: pattern T,T,N repeated 12 times at 0x100 -> final-period mispredicts=0. GHR after the last update = 2'b10.
6. Train 0x100, then flush_i and upd_valid_i in the same cycle -> next cycle pred_taken_o=0, update discarded. Same-cycle lookup+update to one index -> old value returned that cycle.
